oled_serial_target: RTL and testbench

- I2C (2-wire) target that emulates the receive side of an SSD1306-style monochrome OLED controller.
- Decodes the write stream produced by our OLED drivers: address byte, control bytes (Co/D#C), commands with arguments, and GDDRAM data bytes.
- Data bytes become framebuffer write strobes with column/page coordinates, using horizontal addressing.
- Used as a display model in simulation and as an on-FPGA sink for loopback and debug of the serial display path.

---
 rtl/oled_serial_target.sv | 262 ++++++++++++++++++++++++++
 tb/tb_oled_serial_target.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/oled_serial_target.sv
// I2C write-only target decoding an SSD1306-style command/data stream into
// framebuffer write strobes (horizontal addressing) and command strobes.
module oled_serial_target #(
    parameter int unsigned SERIAL_BITS   = 8,
    parameter int unsigned SCREEN_WIDTH  = 128,
    parameter int unsigned SCREEN_HEIGHT = 64,
    parameter int unsigned SCREEN_PAGES  = SCREEN_HEIGHT / SERIAL_BITS,
    parameter logic [6:0]  TARGET_ADDR   = 7'h3c,
    parameter int unsigned HCTR_BITS     = $clog2(SCREEN_WIDTH),
    parameter int unsigned PAGE_BITS     = $clog2(SCREEN_PAGES)
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_serial_clk,
    inout  wire                    inout_serial,
    output logic [SERIAL_BITS-1:0] out_pixels,
    output logic [HCTR_BITS-1:0]   out_hpix,
    output logic [PAGE_BITS-1:0]   out_vpage,
    output logic                   out_pix_we,
    output logic [SERIAL_BITS-1:0] out_cmd,
    output logic                   out_cmd_valid,
    output logic                   out_display_on,
    output logic [7:0]             out_contrast,
    output logic                   out_busy
);
    localparam int unsigned BCNT_BITS = $clog2(SERIAL_BITS);
    localparam logic [BCNT_BITS-1:0] LAST_BIT = BCNT_BITS'(SERIAL_BITS - 1);
    localparam logic [SERIAL_BITS-1:0] ADDR_WR = SERIAL_BITS'({TARGET_ADDR, 1'b0});

    typedef enum logic [2:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_CTRL, ST_CTRL_ACK, ST_BYTE, ST_BYTE_ACK, ST_IGNORE
    } state_t;

    function automatic logic [1:0] arg_count(input logic [SERIAL_BITS-1:0] op);
        case (op)
            8'h81, 8'h20, 8'hd5, 8'hd9, 8'ha8, 8'hd3, 8'h8d, 8'hda, 8'hdb: return 2'd1;
            8'h21, 8'h22: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    state_t state_q, state_d;
    logic [1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
    logic scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic [BCNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
    logic [SERIAL_BITS-1:0] shift_q, shift_d, op_q, op_d;
    logic co_q, co_d, dc_q, dc_d, sda_oe_q, sda_oe_d;
    logic [1:0] arg_cnt_q, arg_cnt_d;
    logic [HCTR_BITS-1:0] col_start_q, col_start_d, col_end_q, col_end_d, col_ptr_q, col_ptr_d;
    logic [PAGE_BITS-1:0] page_start_q, page_start_d, page_end_q, page_end_d, page_ptr_q, page_ptr_d;
    logic [SERIAL_BITS-1:0] pixels_q, pixels_d, cmd_q, cmd_d;
    logic [HCTR_BITS-1:0] hpix_q, hpix_d;
    logic [PAGE_BITS-1:0] vpage_q, vpage_d;
    logic pix_we_q, pix_we_d, cmd_valid_q, cmd_valid_d, display_on_q, display_on_d, busy_q, busy_d;
    logic [7:0] contrast_q, contrast_d;

    logic scl, sda, scl_rise, scl_fall, start_det, stop_det, rx_state, ack_state, byte_done;
    logic [SERIAL_BITS-1:0] rx_byte;

    assign inout_serial = sda_oe_q ? 1'b0 : 1'bz;

    always_comb begin
        scl       = scl_sync_q[1];
        sda       = sda_sync_q[1];
        scl_rise  = scl & ~scl_prev_q;
        scl_fall  = ~scl & scl_prev_q;
        start_det = scl & scl_prev_q & sda_prev_q & ~sda;
        stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;
        rx_state  = (state_q == ST_ADDR) || (state_q == ST_CTRL) || (state_q == ST_BYTE);
        ack_state = (state_q == ST_ADDR_ACK) || (state_q == ST_CTRL_ACK) || (state_q == ST_BYTE_ACK);
        rx_byte   = {shift_q[SERIAL_BITS-2:0], sda};
        byte_done = rx_state && scl_rise && (bit_cnt_q == LAST_BIT);
    end

    // State register (plus all other flops)
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q      <= ST_IDLE;
            scl_sync_q   <= '1;
            sda_sync_q   <= '1;
            scl_prev_q   <= 1'b1;
            sda_prev_q   <= 1'b1;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            op_q         <= '0;
            co_q         <= 1'b0;
            dc_q         <= 1'b0;
            sda_oe_q     <= 1'b0;
            arg_cnt_q    <= '0;
            col_start_q  <= '0;
            col_end_q    <= HCTR_BITS'(SCREEN_WIDTH - 1);
            col_ptr_q    <= '0;
            page_start_q <= '0;
            page_end_q   <= PAGE_BITS'(SCREEN_PAGES - 1);
            page_ptr_q   <= '0;
            pixels_q     <= '0;
            hpix_q       <= '0;
            vpage_q      <= '0;
            pix_we_q     <= 1'b0;
            cmd_q        <= '0;
            cmd_valid_q  <= 1'b0;
            display_on_q <= 1'b0;
            contrast_q   <= 8'h7f;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            scl_sync_q   <= scl_sync_d;
            sda_sync_q   <= sda_sync_d;
            scl_prev_q   <= scl_prev_d;
            sda_prev_q   <= sda_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            op_q         <= op_d;
            co_q         <= co_d;
            dc_q         <= dc_d;
            sda_oe_q     <= sda_oe_d;
            arg_cnt_q    <= arg_cnt_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            col_ptr_q    <= col_ptr_d;
            page_start_q <= page_start_d;
            page_end_q   <= page_end_d;
            page_ptr_q   <= page_ptr_d;
            pixels_q     <= pixels_d;
            hpix_q       <= hpix_d;
            vpage_q      <= vpage_d;
            pix_we_q     <= pix_we_d;
            cmd_q        <= cmd_d;
            cmd_valid_q  <= cmd_valid_d;
            display_on_q <= display_on_d;
            contrast_q   <= contrast_d;
            busy_q       <= busy_d;
        end
    end

    // Next-state logic; ACK states exit on the falling edge that releases SDA
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = ST_IDLE;
        end else if (start_det) begin
            state_d = ST_ADDR;
        end else begin
            case (state_q)
                ST_ADDR:     if (byte_done) state_d = (rx_byte == ADDR_WR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK: if (scl_fall && sda_oe_q) state_d = ST_CTRL;
                ST_CTRL:     if (byte_done) state_d = ST_CTRL_ACK;
                ST_CTRL_ACK: if (scl_fall && sda_oe_q) state_d = ST_BYTE;
                ST_BYTE:     if (byte_done) state_d = ST_BYTE_ACK;
                ST_BYTE_ACK: if (scl_fall && sda_oe_q) state_d = co_q ? ST_CTRL : ST_BYTE;
                default:     state_d = state_q;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        scl_sync_d   = {scl_sync_q[0], in_serial_clk};
        sda_sync_d   = {sda_sync_q[0], inout_serial};
        scl_prev_d   = scl;
        sda_prev_d   = sda;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        op_d         = op_q;
        co_d         = co_q;
        dc_d         = dc_q;
        sda_oe_d     = 1'b0;
        arg_cnt_d    = arg_cnt_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        col_ptr_d    = col_ptr_q;
        page_start_d = page_start_q;
        page_end_d   = page_end_q;
        page_ptr_d   = page_ptr_q;
        pixels_d     = pixels_q;
        hpix_d       = hpix_q;
        vpage_d      = vpage_q;
        pix_we_d     = 1'b0;
        cmd_d        = cmd_q;
        cmd_valid_d  = 1'b0;
        display_on_d = display_on_q;
        contrast_d   = contrast_q;
        busy_d       = (state_d == ST_ADDR_ACK) || (state_d == ST_CTRL) || (state_d == ST_CTRL_ACK) ||
                       (state_d == ST_BYTE) || (state_d == ST_BYTE_ACK);

        if (start_det || stop_det || ack_state) begin
            bit_cnt_d = '0;
        end else if (rx_state && scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shift_d   = rx_byte;
        end

        // First falling edge in an ACK state pulls SDA low, the second releases it
        if (ack_state && !start_det && !stop_det) begin
            sda_oe_d = scl_fall ? ~sda_oe_q : sda_oe_q;
        end

        if (byte_done && state_q == ST_CTRL) begin
            co_d = rx_byte[SERIAL_BITS-1];
            dc_d = rx_byte[SERIAL_BITS-2];
        end

        if (byte_done && state_q == ST_BYTE) begin
            if (dc_q) begin
                pixels_d = rx_byte;
                hpix_d   = col_ptr_q;
                vpage_d  = page_ptr_q;
                pix_we_d = 1'b1;
                if (col_ptr_q == col_end_q || col_start_q > col_end_q) begin
                    col_ptr_d = col_start_q;
                    if (page_ptr_q == page_end_q || page_start_q > page_end_q)
                        page_ptr_d = page_start_q;
                    else
                        page_ptr_d = page_ptr_q + 1'b1;
                end else begin
                    col_ptr_d = col_ptr_q + 1'b1;
                end
            end else begin
                cmd_d       = rx_byte;
                cmd_valid_d = 1'b1;
                if (arg_cnt_q == 2'd0) begin
                    op_d      = rx_byte;
                    arg_cnt_d = arg_count(rx_byte);
                    if (rx_byte == 8'hae) display_on_d = 1'b0;
                    if (rx_byte == 8'haf) display_on_d = 1'b1;
                end else begin
                    arg_cnt_d = arg_cnt_q - 1'b1;
                    case (op_q)
                        8'h81: contrast_d = rx_byte[7:0];
                        8'h21: begin
                            if (arg_cnt_q == 2'd2) begin
                                col_start_d = rx_byte[HCTR_BITS-1:0];
                                col_ptr_d   = rx_byte[HCTR_BITS-1:0];
                            end else begin
                                col_end_d = rx_byte[HCTR_BITS-1:0];
                            end
                        end
                        8'h22: begin
                            if (arg_cnt_q == 2'd2) begin
                                page_start_d = rx_byte[PAGE_BITS-1:0];
                                page_ptr_d   = rx_byte[PAGE_BITS-1:0];
                            end else begin
                                page_end_d = rx_byte[PAGE_BITS-1:0];
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign out_pixels     = pixels_q;
    assign out_hpix       = hpix_q;
    assign out_vpage      = vpage_q;
    assign out_pix_we     = pix_we_q;
    assign out_cmd        = cmd_q;
    assign out_cmd_valid  = cmd_valid_q;
    assign out_display_on = display_on_q;
    assign out_contrast   = contrast_q;
    assign out_busy       = busy_q;
endmodule

// File: tb/tb_oled_serial_target.sv
// Directed bench for oled_serial_target: bit-banged I2C master, strobe logging
// and hand-computed expectations.
`timescale 1ns/1ps
module tb_oled_serial_target;
    localparam int Q = 50;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl = 1'b1;
    logic sda_low = 1'b0;
    wire  sda;

    logic [7:0] pixels;
    logic [6:0] hpix;
    logic [2:0] vpage;
    logic       pix_we;
    logic [7:0] cmd;
    logic       cmd_valid;
    logic       display_on;
    logic [7:0] contrast;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int dut_low_cnt = 0;
    logic [17:0] pix_log[$];
    logic [7:0]  cmd_log[$];
    logic ack;

    assign sda = sda_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    oled_serial_target #(.TARGET_ADDR(7'h3c)) dut (
        .in_clk(clk),
        .in_rst(rst_n),
        .in_serial_clk(scl),
        .inout_serial(sda),
        .out_pixels(pixels),
        .out_hpix(hpix),
        .out_vpage(vpage),
        .out_pix_we(pix_we),
        .out_cmd(cmd),
        .out_cmd_valid(cmd_valid),
        .out_display_on(display_on),
        .out_contrast(contrast),
        .out_busy(busy)
    );

    always @(negedge clk) begin
        if (pix_we) pix_log.push_back({vpage, hpix, pixels});
        if (cmd_valid) cmd_log.push_back(cmd);
        if (sda == 1'b0 && !sda_low) dut_low_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_low = 1'b0; #Q;
        scl = 1'b1;     #Q;
        sda_low = 1'b1; #Q;
        scl = 1'b0;     #Q;
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1; #Q;
        scl = 1'b1;     #Q;
        sda_low = 1'b0; #Q;
    endtask

    task automatic write_bit(input logic b);
        sda_low = !b; #Q;
        scl = 1'b1;   #(2*Q);
        scl = 1'b0;   #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sda_low = 1'b0; #Q;
        scl = 1'b1;     #Q;
        a = (sda == 1'b0);
        #Q;
        scl = 1'b0;     #Q;
    endtask

    function automatic logic [17:0] pix_at(input int idx);
        return (idx < pix_log.size()) ? pix_log[idx] : 18'h3ffff;
    endfunction

    function automatic logic [7:0] cmd_at(input int idx);
        return (idx < cmd_log.size()) ? cmd_log[idx] : 8'hxx;
    endfunction

    initial begin
        int low_base;
        logic [7:0] addr_byte;

        #50;
        check("rst_pix_we", pix_we, 0);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_display", display_on, 0);
        check("rst_contrast", contrast, 8'h7f);
        check("rst_busy", busy, 0);
        check("rst_sda", sda, 1);
        check("rst_hpix", hpix, 0);
        rst_n = 1'b1;
        #100;

        // Display on: three ACKs, one command strobe
        i2c_start();
        send_byte(8'h78, ack); check("t1_ack_addr", ack, 1);
        check("t1_busy", busy, 1);
        send_byte(8'h80, ack); check("t1_ack_ctrl", ack, 1);
        send_byte(8'haf, ack); check("t1_ack_cmd", ack, 1);
        i2c_stop(); #100;
        check("t1_cmd_cnt", cmd_log.size(), 1);
        check("t1_cmd", cmd_at(0), 8'haf);
        check("t1_display", display_on, 1);
        check("t1_busy_idle", busy, 0);

        // Data stream from pointer origin
        pix_log.delete(); cmd_log.delete();
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h40, ack);
        send_byte(8'h11, ack); check("t2_ack_data", ack, 1);
        send_byte(8'h22, ack);
        send_byte(8'h33, ack);
        i2c_stop(); #100;
        check("t2_we_cnt", pix_log.size(), 3);
        check("t2_w0", pix_at(0), {3'd0, 7'd0, 8'h11});
        check("t2_w1", pix_at(1), {3'd0, 7'd1, 8'h22});
        check("t2_w2", pix_at(2), {3'd0, 7'd2, 8'h33});
        check("t2_no_cmd", cmd_log.size(), 0);

        // Column window 126..127 wraps and advances the page
        pix_log.delete(); cmd_log.delete();
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h00, ack);
        send_byte(8'h21, ack);
        send_byte(8'h7e, ack);
        send_byte(8'h7f, ack);
        i2c_stop(); #100;
        check("t3_cmd_cnt", cmd_log.size(), 3);
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h40, ack);
        send_byte(8'ha1, ack);
        send_byte(8'ha2, ack);
        send_byte(8'ha3, ack);
        i2c_stop(); #100;
        check("t3_we_cnt", pix_log.size(), 3);
        check("t3_w0", pix_at(0), {3'd0, 7'd126, 8'ha1});
        check("t3_w1", pix_at(1), {3'd0, 7'd127, 8'ha2});
        check("t3_w2", pix_at(2), {3'd1, 7'd126, 8'ha3});

        // Wrong address and read form are ignored
        pix_log.delete(); cmd_log.delete();
        low_base = dut_low_cnt;
        i2c_start();
        send_byte(8'h7a, ack); check("t4_nack_7a", ack, 0);
        check("t4_busy", busy, 0);
        send_byte(8'h40, ack);
        send_byte(8'h55, ack);
        i2c_stop(); #100;
        i2c_start();
        send_byte(8'h7b, ack); check("t4_nack_7b", ack, 0);
        i2c_stop(); #100;
        i2c_start();
        send_byte(8'h79, ack); check("t4_nack_79", ack, 0);
        i2c_stop(); #100;
        check("t4_sda_never_low", dut_low_cnt - low_base, 0);
        check("t4_no_we", pix_log.size(), 0);
        check("t4_no_cmd", cmd_log.size(), 0);

        // Argument counter survives a Co=1 control pair
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h80, ack);
        send_byte(8'h81, ack);
        send_byte(8'h80, ack);
        send_byte(8'h20, ack);
        i2c_stop(); #100;
        check("t5_cmd_cnt", cmd_log.size(), 2);
        check("t5_contrast", contrast, 8'h20);
        check("t5_display", display_on, 1);

        // Contrast via plain command stream
        cmd_log.delete();
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h00, ack);
        send_byte(8'h81, ack);
        send_byte(8'h40, ack);
        i2c_stop(); #100;
        check("t6_cmd_cnt", cmd_log.size(), 2);
        check("t6_cmd0", cmd_at(0), 8'h81);
        check("t6_cmd1", cmd_at(1), 8'h40);
        check("t6_contrast", contrast, 8'h40);

        // Partial data byte at STOP, then reset while ACK is driven
        pix_log.delete(); cmd_log.delete();
        i2c_start();
        send_byte(8'h78, ack);
        send_byte(8'h40, ack);
        for (int i = 0; i < 5; i++) write_bit(i[0]);
        i2c_stop(); #100;
        check("t7_partial_no_we", pix_log.size(), 0);
        i2c_start();
        addr_byte = 8'h78;
        for (int i = 7; i >= 0; i--) write_bit(addr_byte[i]);
        sda_low = 1'b0; #Q;
        check("t7_ack_driven", sda, 0);
        rst_n = 1'b0; #1;
        check("t7_sda_released", sda, 1);
        check("t7_display", display_on, 0);
        check("t7_contrast", contrast, 8'h7f);
        check("t7_busy", busy, 0);
        check("t7_cmd", cmd, 0);
        scl = 1'b1; #100;
        rst_n = 1'b1; #100;
        check("t7_no_we", pix_log.size(), 0);
        check("t7_no_cmd", cmd_log.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
